// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer driving an external 4-bit shifter_core.
// Large amounts are applied as repeated steps of at most 3 positions.
module shift_sequencer #(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [3:0]       req_data,
    input  logic [AMT_W-1:0] req_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_data,
    output logic [AMT_W-1:0] rsp_steps,
    output logic             busy,
    output logic [3:0]       core_A,
    output logic [1:0]       core_B,
    output logic [1:0]       core_C,
    output logic [2:0]       core_F,
    input  logic [3:0]       core_Y
);

    // state  | meaning
    // IDLE   | waiting for a request, req_ready high
    // RUN    | one core step per cycle, acc fed back through the core
    // DONE   | result held on rsp_* until the consumer takes it
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [2:0]       op;
    logic [3:0]       acc;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] steps;

    logic [1:0]       step;
    logic             single_cycle;
    logic [AMT_W-1:0] rem_next;

    always_comb begin
        step         = (rem > AMT_W'(3)) ? 2'd3 : rem[1:0];
        single_cycle = (op == 3'b000) || (op == 3'b110) || (op == 3'b111);
        // pass/shl1/zero ignore the amount, so they finish in one step
        rem_next     = single_cycle ? '0 : (rem - AMT_W'(step));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op    <= '0;
            acc   <= '0;
            rem   <= '0;
            steps <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op    <= req_op;
                        acc   <= req_data;
                        rem   <= req_amt;
                        steps <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= core_Y;
                    rem   <= rem_next;
                    steps <= steps + AMT_W'(1);
                    if (rem_next == '0)
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);
    assign rsp_data  = (state == S_DONE) ? acc : 4'd0;
    assign rsp_steps = (state == S_DONE) ? steps : '0;

    assign core_A = acc;
    assign core_B = (state == S_RUN) ? step : 2'd0;
    assign core_C = (state == S_RUN) ? step : 2'd0;
    assign core_F = (state == S_RUN) ? op : 3'b000;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural shifter_core model
// closing the core_* loop.
module tb_shift_sequencer;

    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [3:0]       req_data;
    logic [AMT_W-1:0] req_amt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_data;
    logic [AMT_W-1:0] rsp_steps;
    logic             busy;
    logic [3:0]       core_A;
    logic [1:0]       core_B;
    logic [1:0]       core_C;
    logic [2:0]       core_F;
    logic [3:0]       core_Y;

    typedef struct {
        logic [3:0] data;
        int         steps;
    } rsp_t;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [1:0] s;
    } step_t;

    rsp_t  exp_q[$];
    step_t step_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int accept_cyc = 0;
    logic prev_rsp_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_sequencer #(.AMT_W(AMT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .req_amt(req_amt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_steps(rsp_steps), .busy(busy),
        .core_A(core_A), .core_B(core_B), .core_C(core_C),
        .core_F(core_F), .core_Y(core_Y)
    );

    function automatic logic [3:0] core_fn(input logic [2:0] f, input logic [3:0] a,
                                           input logic [1:0] b, input logic [1:0] c);
        logic [7:0] dbl;
        logic signed [3:0] sa;
        sa  = a;
        dbl = {a, a};
        case (f)
            3'b000: return a;
            3'b001: return a << b;
            3'b010: return a >> b;
            3'b011: return 4'(sa >>> b);
            3'b100: begin dbl = dbl << c; return dbl[7:4]; end
            3'b101: begin dbl = dbl >> c; return dbl[3:0]; end
            3'b110: return a << 1;
            default: return 4'd0;
        endcase
    endfunction

    assign core_Y = core_fn(core_F, core_A, core_B, core_C);

    // Closed-form reference, independent of step iteration.
    function automatic logic [3:0] ref_result(input logic [2:0] o, input logic [3:0] d, input int amt);
        logic signed [3:0] sd;
        logic [7:0] dbl;
        sd  = d;
        dbl = {d, d};
        case (o)
            3'b000: return d;
            3'b001: return (amt >= 4) ? 4'd0 : 4'(d << amt);
            3'b010: return (amt >= 4) ? 4'd0 : 4'(d >> amt);
            3'b011: return (amt >= 4) ? {4{d[3]}} : 4'(sd >>> amt);
            3'b100: begin dbl = dbl << (amt % 4); return dbl[7:4]; end
            3'b101: begin dbl = dbl >> (amt % 4); return dbl[3:0]; end
            3'b110: return d << 1;
            default: return 4'd0;
        endcase
    endfunction

    function automatic int ref_steps(input logic [2:0] o, input int amt);
        if (o == 3'b000 || o == 3'b110 || o == 3'b111) return 1;
        if (amt == 0) return 1;
        return (amt + 2) / 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready)
                accept_cyc = cyc + 1;
            if (busy && !rsp_valid) begin
                if (step_q.size() == 0) begin
                    check("step_underflow", 32'd1, 32'd0);
                end else begin
                    step_t st;
                    st = step_q.pop_front();
                    check("core_F", 32'(core_F), 32'(st.op));
                    check("core_A", 32'(core_A), 32'(st.a));
                    check("core_B", 32'(core_B), 32'(st.s));
                    check("core_C", 32'(core_C), 32'(st.s));
                end
            end
            if (rsp_valid) begin
                check("no_ready_in_done", 32'(req_ready), 32'd0);
                if (!prev_rsp_valid && exp_q.size() != 0)
                    check("latency", 32'(cyc - accept_cyc), 32'(exp_q[0].steps));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_steps", 32'(rsp_steps), 32'(e.steps));
                end
            end
            prev_rsp_valid = rsp_valid;
        end else begin
            prev_rsp_valid = 1'b0;
        end
    end

    task automatic start_op(input logic [2:0] o, input logic [3:0] d, input int amt);
        rsp_t  e;
        step_t st;
        int    rem;
        logic [3:0] a;
        bit    ok;
        e.data  = ref_result(o, d, amt);
        e.steps = ref_steps(o, amt);
        exp_q.push_back(e);
        rem = amt;
        a   = d;
        do begin
            st.op = o;
            st.a  = a;
            st.s  = (rem > 3) ? 2'd3 : 2'(rem);
            step_q.push_back(st);
            a = core_fn(o, a, st.s, st.s);
            if (o == 3'b000 || o == 3'b110 || o == 3'b111) rem = 0;
            else rem = rem - int'(st.s);
        end while (rem != 0);
        req_op    = o;
        req_data  = d;
        req_amt   = AMT_W'(amt);
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        check("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        check("rsp_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [3:0] d, input int amt);
        start_op(o, d, amt);
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        check({tag, "_rsp_steps"}, 32'(rsp_steps), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_core"}, 32'({core_A, core_B, core_C, core_F}), 32'd0);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_data  = '0;
        req_amt   = '0;
        rsp_ready = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_op(3'b001, 4'b0011, 1);
        run_op(3'b011, 4'b1000, 7);
        run_op(3'b100, 4'b1001, 5);
        run_op(3'b101, 4'b0001, 0);
        run_op(3'b111, 4'b1111, 9);
        run_op(3'b001, 4'b0001, 15);
        run_op(3'b110, 4'b0101, 6);
        run_op(3'b010, 4'b1100, 3);

        for (int i = 0; i < 24; i++)
            run_op(3'($urandom_range(7)), 4'($urandom_range(15)), int'($urandom_range(15)));

        // Backpressure with spurious request pulses.
        rsp_ready = 1'b0;
        start_op(3'b011, 4'b1000, 7);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        check("bp_rsp_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            req_valid = (i % 2 == 0);
            req_op    = 3'b000;
            req_data  = 4'b0110;
            req_amt   = '0;
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'hf);
            check("bp_rsp_steps", 32'(rsp_steps), 32'd3);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        check("bp_rsp_drop", 32'(rsp_valid), 32'd0);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Mid-operation reset during the second RUN cycle.
        start_op(3'b010, 4'b1111, 15);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        step_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        run_op(3'b000, 4'b1010, 0);
        run_op(3'b100, 4'b0110, 2);

        check("final_step_q", 32'(step_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
